// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit registered multiplexer with three modes.
// Direct mode selects the channel on s. Scan mode steps round-robin through the
// channels, staying dwell+1 cycles on each. Hold mode freezes the output.
// y/ch are qualified by y_valid; wrap marks the scan sample taken from channel N-1.
module mux_nx1_scan #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  i,
  input  logic [SW-1:0]   s,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   dwell,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            y_valid,
  output logic            wrap
);

  localparam int unsigned SWX = SW + 1;
  localparam logic [SW-1:0]  LAST_CH   = SW'(N - 1);
  localparam logic [SWX-1:0] N_EXT     = SWX'(N);
  localparam logic [1:0]     MODE_DIR  = 2'b00;
  localparam logic [1:0]     MODE_SCAN = 2'b01;

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          y_valid_q, y_valid_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [DW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  s_data;
  logic [W-1:0]  cur_data;
  logic          s_in_range;

  // Select one channel; an index beyond the last channel yields zero.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                        input logic [SW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = bus[k*W +: W];
    end
    return r;
  endfunction

  // Channel data for both the direct select and the scan pointer.
  always_comb begin
    s_data     = pick(i, s);
    cur_data   = pick(i, cur_q);
    s_in_range = ({1'b0, s} < N_EXT);
  end

  // Next-state: en gates everything, then mode picks direct / scan / hold.
  always_comb begin
    y_d       = y_q;
    ch_d      = ch_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    y_valid_d = 1'b0;
    wrap_d    = 1'b0;
    if (en) begin
      case (mode)
        MODE_DIR: begin
          y_d       = s_data;
          ch_d      = s;
          y_valid_d = 1'b1;
          cur_d     = s_in_range ? s : '0;
          cnt_d     = '0;
        end
        MODE_SCAN: begin
          // >= so a dwell lowered below the running count samples at once.
          if (cnt_q >= dwell) begin
            y_d       = cur_data;
            ch_d      = cur_q;
            y_valid_d = 1'b1;
            cnt_d     = '0;
            if (cur_q == LAST_CH) begin
              cur_d  = '0;
              wrap_d = 1'b1;
            end else begin
              cur_d  = cur_q + SW'(1);
            end
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      ch_q      <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      cur_q     <= '0;
      cnt_q     <= '0;
    end else begin
      y_q       <= y_d;
      ch_q      <= ch_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y       = y_q;
  assign ch      = ch_q;
  assign y_valid = y_valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed, table-driven bench for mux_nx1_scan (8x8 and 5x16 instances).
module tb_mux_nx1_scan;

  typedef struct {
    bit          rst;
    logic [1:0]  mode;
    logic [2:0]  s;
    logic [7:0]  dwell;
    logic        en;
    logic [15:0] ey;
    logic [2:0]  ech;
    logic        ev;
    logic        ew;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [63:0] i_a;
  logic [2:0]  s_a;
  logic [1:0]  mode_a;
  logic [7:0]  dwell_a;
  logic        en_a;
  logic [7:0]  y_a;
  logic [2:0]  ch_a;
  logic        yv_a, wr_a;

  logic [79:0] i_b;
  logic [2:0]  s_b;
  logic [1:0]  mode_b;
  logic [7:0]  dwell_b;
  logic        en_b;
  logic [15:0] y_b;
  logic [2:0]  ch_b;
  logic        yv_b, wr_b;

  int n_cmp = 0;
  int n_err = 0;

  vec_t va[$];
  vec_t vb[$];

  mux_nx1_scan #(.N(8), .W(8), .SW(3), .DW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .i(i_a), .s(s_a), .mode(mode_a),
    .dwell(dwell_a), .en(en_a), .y(y_a), .ch(ch_a), .y_valid(yv_a), .wrap(wr_a)
  );

  mux_nx1_scan #(.N(5), .W(16), .SW(3), .DW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .i(i_b), .s(s_b), .mode(mode_b),
    .dwell(dwell_b), .en(en_b), .y(y_b), .ch(ch_b), .y_valid(yv_b), .wrap(wr_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, logic [1:0] mode, logic [2:0] s,
                              logic [7:0] dwell, logic en, logic [15:0] ey,
                              logic [2:0] ech, logic ev, logic ew);
    vec_t v;
    v.rst = rst; v.mode = mode; v.s = s; v.dwell = dwell; v.en = en;
    v.ey = ey; v.ech = ech; v.ev = ev; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: optional reset pulse, drive, clock once, check.
  task automatic apply_a(input vec_t v, input int idx);
    if (v.rst) begin rst_n = 1'b0; #1; rst_n = 1'b1; end
    mode_a = v.mode; s_a = v.s; dwell_a = v.dwell; en_a = v.en;
    @(posedge clk); @(negedge clk);
    chk($sformatf("a[%0d].y", idx),       16'(y_a), v.ey);
    chk($sformatf("a[%0d].ch", idx),      16'(ch_a), 16'(v.ech));
    chk($sformatf("a[%0d].y_valid", idx), 16'(yv_a), 16'(v.ev));
    chk($sformatf("a[%0d].wrap", idx),    16'(wr_a), 16'(v.ew));
  endtask

  task automatic apply_b(input vec_t v, input int idx);
    if (v.rst) begin rst_n = 1'b0; #1; rst_n = 1'b1; end
    mode_b = v.mode; s_b = v.s; dwell_b = v.dwell; en_b = v.en;
    @(posedge clk); @(negedge clk);
    chk($sformatf("b[%0d].y", idx),       y_b, v.ey);
    chk($sformatf("b[%0d].ch", idx),      16'(ch_b), 16'(v.ech));
    chk($sformatf("b[%0d].y_valid", idx), 16'(yv_b), 16'(v.ev));
    chk($sformatf("b[%0d].wrap", idx),    16'(wr_b), 16'(v.ew));
  endtask

  initial begin
    int          last;
    logic [15:0] hy;
    logic [2:0]  hc;

    for (int k = 0; k < 8; k++) i_a[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 5; k++) i_b[k*16 +: 16] = 16'hC0C0 + 16'(k);

    // Direct sweep 0..7, then en=0 holds y and drops y_valid.
    for (int k = 0; k < 8; k++)
      va.push_back(mk(0, 2'b00, 3'(k), 8'd0, 1'b1, 16'hA0 + 16'(k), 3'(k), 1'b1, 1'b0));
    for (int k = 0; k < 3; k++)
      va.push_back(mk(0, 2'b00, 3'd0, 8'd0, 1'b0, 16'h00A7, 3'd7, 1'b0, 1'b0));
    // Scan dwell=0 from reset: 0..7,0,1 with wrap on 7.
    for (int k = 0; k < 10; k++)
      va.push_back(mk(k == 0, 2'b01, 3'd0, 8'd0, 1'b1, 16'hA0 + 16'(k % 8),
                      3'(k % 8), 1'b1, (k % 8) == 7));
    // One direct cycle s=6, then scan dwell=2 samples 6,7,0,1 every 3rd cycle.
    va.push_back(mk(0, 2'b00, 3'd6, 8'd0, 1'b1, 16'h00A6, 3'd6, 1'b1, 1'b0));
    last = 6;
    hc = 3'd6;
    for (int c = 1; c <= 12; c++) begin
      if (c % 3 == 0) begin
        hc = 3'((last + c / 3 - 1) % 8);
        va.push_back(mk(0, 2'b01, 3'd0, 8'd2, 1'b1, 16'hA0 + 16'(hc), hc, 1'b1, hc == 3'd7));
      end else begin
        va.push_back(mk(0, 2'b01, 3'd0, 8'd2, 1'b1, 16'hA0 + 16'(hc), hc, 1'b0, 1'b0));
      end
    end
    // Hold (both encodings) for 5 cycles, then scan resumes at channel 2.
    for (int k = 0; k < 5; k++)
      va.push_back(mk(0, (k % 2) ? 2'b11 : 2'b10, 3'd0, 8'd2, 1'b1, 16'h00A1, 3'd1, 1'b0, 1'b0));
    va.push_back(mk(0, 2'b01, 3'd0, 8'd2, 1'b1, 16'h00A1, 3'd1, 1'b0, 1'b0));
    va.push_back(mk(0, 2'b01, 3'd0, 8'd2, 1'b1, 16'h00A1, 3'd1, 1'b0, 1'b0));
    va.push_back(mk(0, 2'b01, 3'd0, 8'd2, 1'b1, 16'h00A2, 3'd2, 1'b1, 1'b0));
    // Dwell shrink: 7 idle cycles at dwell=10, then dwell=3 samples next edge.
    for (int k = 0; k < 7; k++)
      va.push_back(mk(k == 0, 2'b01, 3'd0, 8'd10, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0));
    va.push_back(mk(0, 2'b01, 3'd0, 8'd3, 1'b1, 16'h00A0, 3'd0, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++)
      va.push_back(mk(0, 2'b01, 3'd0, 8'd3, 1'b1, 16'h00A0, 3'd0, 1'b0, 1'b0));
    va.push_back(mk(0, 2'b01, 3'd0, 8'd3, 1'b1, 16'h00A1, 3'd1, 1'b1, 1'b0));

    // N=5, W=16: in-range direct, out-of-range direct, then scan 0..4,0.
    vb.push_back(mk(0, 2'b00, 3'd3, 8'd0, 1'b1, 16'hC0C3, 3'd3, 1'b1, 1'b0));
    vb.push_back(mk(0, 2'b00, 3'd6, 8'd0, 1'b1, 16'h0000, 3'd6, 1'b1, 1'b0));
    for (int k = 0; k < 6; k++)
      vb.push_back(mk(0, 2'b01, 3'd0, 8'd0, 1'b1, 16'hC0C0 + 16'(k % 5),
                      3'(k % 5), 1'b1, (k % 5) == 4));

    // Reset and the asynchronous-assertion sequence.
    rst_n = 1'b0;
    s_a = 3'd2; mode_a = 2'b00; dwell_a = 8'd0; en_a = 1'b0;
    s_b = 3'd0; mode_b = 2'b10; dwell_b = 8'd0; en_b = 1'b0;
    @(negedge clk);
    chk("reset.y", 16'(y_a), 16'h0000);
    chk("reset.y_valid", 16'(yv_a), 16'h0000);
    rst_n = 1'b1;
    en_a = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre_async.y", 16'(y_a), 16'h00A2);
    chk("pre_async.y_valid", 16'(yv_a), 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async.y", 16'(y_a), 16'h0000);
    chk("async.ch", 16'(ch_a), 16'h0000);
    chk("async.y_valid", 16'(yv_a), 16'h0000);
    chk("async.wrap", 16'(wr_a), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    s_a = 3'd5;
    @(posedge clk); @(negedge clk);
    chk("release.y", 16'(y_a), 16'h00A5);
    chk("release.ch", 16'(ch_a), 16'h0005);
    chk("release.y_valid", 16'(yv_a), 16'h0001);
    chk("release.wrap", 16'(wr_a), 16'h0000);

    foreach (va[n]) apply_a(va[n], n);
    en_a = 1'b0;
    foreach (vb[n]) apply_b(vb[n], n);

    hy = y_b;
    en_b = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b_en0.y", y_b, 16'hC0C0);
    chk("b_en0.y_valid", 16'(yv_b), 16'h0000);
    if (hy !== 16'hC0C0) $display("FAIL b_final.y: got %h expected %h", hy, 16'hC0C0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
